// File: rtl/sm83_flags_ctrl.sv
// Flag-update sequencer: turns a decoded flag-affecting operation into the
// per-cycle write/select strobes consumed by the ALU flags register, and owns
// the secondary-carry selection state.
//
// state | meaning
// IDLE  | no operation in flight, ready to accept
// STEP1 | first strobe cycle of the latched operation
// STEP2 | second strobe cycle (ADD16 high byte, DAA flag write-back)
module sm83_flags_ctrl #(
    parameter int OP_W = 3
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            op_valid_i,
    input  logic [OP_W-1:0] op_i,
    output logic            op_ready_o,
    input  logic            hold_i,
    output logic            done_o,
    output logic            flags_bus_o,
    output logic            flags_alu_o,
    output logic            zero_we_o,
    output logic            zero_clr_o,
    output logic            half_carry_we_o,
    output logic            daa_carry_we_o,
    output logic            neg_we_o,
    output logic            neg_set_o,
    output logic            neg_clr_o,
    output logic            carry_we_o,
    output logic            sec_carry_we_o,
    output logic            sec_carry_sh_o,
    output logic            sec_carry_daa_o,
    output logic            sec_carry_sel_o
);

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_INC   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DEC   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_POPAF = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADD16 = OP_W'(5);
    localparam logic [OP_W-1:0] OP_DAA   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHIFT = OP_W'(7);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP1 = 2'd1,
        ST_STEP2 = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            sec_sel_q, sec_sel_d;

    logic two_step;
    logic final_step;
    logic op_ready;
    logic accept;
    logic active;

    // Handshake: ready in IDLE or on an unstalled final step, so ops can
    // issue back to back without a bubble.
    always_comb begin
        two_step   = (op_q == OP_ADD16) || (op_q == OP_DAA);
        final_step = ((state_q == ST_STEP1) && !two_step) || (state_q == ST_STEP2);
        op_ready   = (state_q == ST_IDLE) || (final_step && !hold_i);
        accept     = op_valid_i && op_ready;
        active     = !hold_i && ((state_q == ST_STEP1) || (state_q == ST_STEP2));
    end

    assign op_ready_o = op_ready;

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            sec_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            sec_sel_q <= sec_sel_d;
        end
    end

    // Next-state: advance only when not stalled; carry-source selection
    // commits on the final step.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sec_sel_d = sec_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_STEP1;
            end
            ST_STEP1, ST_STEP2: begin
                if (!hold_i) begin
                    if (final_step) begin
                        state_d = accept ? ST_STEP1 : ST_IDLE;
                        case (op_q)
                            OP_SHIFT, OP_DAA:                   sec_sel_d = 1'b1;
                            OP_ADD, OP_SUB, OP_POPAF, OP_ADD16: sec_sel_d = 1'b0;
                            default:                            sec_sel_d = sec_sel_q;
                        endcase
                    end else begin
                        state_d = ST_STEP2;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) op_d = op_i;
    end

    // Moore strobe decode from state and latched op; a stall masks everything.
    always_comb begin
        flags_bus_o     = 1'b0;
        flags_alu_o     = 1'b0;
        zero_we_o       = 1'b0;
        zero_clr_o      = 1'b0;
        half_carry_we_o = 1'b0;
        daa_carry_we_o  = 1'b0;
        neg_we_o        = 1'b0;
        neg_set_o       = 1'b0;
        neg_clr_o       = 1'b0;
        carry_we_o      = 1'b0;
        sec_carry_we_o  = 1'b0;
        sec_carry_sh_o  = 1'b0;
        sec_carry_daa_o = 1'b0;
        done_o          = active && final_step;
        if (active && (state_q == ST_STEP1)) begin
            case (op_q)
                OP_ADD, OP_SUB: begin
                    flags_alu_o     = 1'b1;
                    zero_we_o       = 1'b1;
                    half_carry_we_o = 1'b1;
                    daa_carry_we_o  = 1'b1;
                    neg_we_o        = 1'b1;
                    neg_set_o       = (op_q == OP_SUB);
                    neg_clr_o       = (op_q == OP_ADD);
                    carry_we_o      = 1'b1;
                end
                OP_INC, OP_DEC: begin
                    flags_alu_o     = 1'b1;
                    zero_we_o       = 1'b1;
                    half_carry_we_o = 1'b1;
                    neg_we_o        = 1'b1;
                    neg_set_o       = (op_q == OP_DEC);
                    neg_clr_o       = (op_q == OP_INC);
                end
                OP_POPAF: begin
                    flags_bus_o     = 1'b1;
                    zero_we_o       = 1'b1;
                    half_carry_we_o = 1'b1;
                    neg_we_o        = 1'b1;
                    carry_we_o      = 1'b1;
                end
                OP_ADD16: begin
                    sec_carry_we_o  = 1'b1;
                end
                OP_DAA: begin
                    sec_carry_we_o  = 1'b1;
                    sec_carry_daa_o = 1'b1;
                end
                default: begin
                    flags_alu_o     = 1'b1;
                    zero_we_o       = 1'b1;
                    neg_we_o        = 1'b1;
                    neg_clr_o       = 1'b1;
                    sec_carry_we_o  = 1'b1;
                    sec_carry_sh_o  = 1'b1;
                end
            endcase
        end else if (active && (state_q == ST_STEP2)) begin
            if (op_q == OP_ADD16) begin
                flags_alu_o     = 1'b1;
                half_carry_we_o = 1'b1;
                neg_we_o        = 1'b1;
                neg_clr_o       = 1'b1;
                carry_we_o      = 1'b1;
            end else begin
                flags_alu_o     = 1'b1;
                zero_we_o       = 1'b1;
                half_carry_we_o = 1'b1;
            end
        end
    end

    // The high byte of ADD16 always consumes the low-byte carry, even while
    // stalled, so the carry mux stays steady across the stall.
    always_comb begin
        sec_carry_sel_o = sec_sel_q;
        if ((state_q == ST_STEP2) && (op_q == OP_ADD16)) sec_carry_sel_o = 1'b1;
    end

endmodule
